// File: rtl/smart_light_ctrl.sv
// Multi-channel lighting controller: one auto/manual lamp FSM per channel with
// an occupancy hold-off timer, ambient gating, button edge detect and all-off override.
module smart_light_ctrl #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            mode_btn,
    input  logic [N_CH-1:0]            lamp_btn,
    input  logic [N_CH-1:0]            presence,
    input  logic                       dark,
    input  logic                       all_off,
    output logic [N_CH-1:0]            led_manual,
    output logic [N_CH-1:0]            lamp_on,
    output logic [$clog2(N_CH+1)-1:0]  on_count
);
    localparam int CW = $clog2(N_CH + 1);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        AUTO_OFF = 2'b00,
        AUTO_ON  = 2'b01,
        MAN_OFF  = 2'b10,
        MAN_ON   = 2'b11
    } state_t;

    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [TW-1:0]   timer_q [N_CH];
    logic [TW-1:0]   timer_d [N_CH];
    logic [N_CH-1:0] mode_prev;
    logic [N_CH-1:0] lamp_prev;
    logic [N_CH-1:0] mode_evt;
    logic [N_CH-1:0] lamp_evt;
    logic [N_CH-1:0] lamp_next;
    logic [CW-1:0]   count_next;

    assign mode_evt = mode_btn & ~mode_prev;
    assign lamp_evt = lamp_btn & ~lamp_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= AUTO_OFF;
                timer_q[i] <= '0;
            end
            mode_prev <= '0;
            lamp_prev <= '0;
            on_count  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            mode_prev <= mode_btn;
            lamp_prev <= lamp_btn;
            on_count  <= count_next;
        end
    end

    // Timer defaults to 0 so it is only non-zero while a channel sits in AUTO_ON.
    always_comb begin
        lamp_next  = '0;
        count_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = '0;
            if (all_off) begin
                state_d[i] = AUTO_OFF;
            end else if (mode_evt[i]) begin
                case (state_q[i])
                    AUTO_OFF: state_d[i] = MAN_OFF;
                    AUTO_ON:  state_d[i] = MAN_ON;
                    MAN_OFF:  state_d[i] = AUTO_OFF;
                    MAN_ON: begin
                        state_d[i] = AUTO_ON;
                        timer_d[i] = HOLD_LOAD;
                    end
                    default:  state_d[i] = AUTO_OFF;
                endcase
            end else begin
                case (state_q[i])
                    MAN_OFF: if (lamp_evt[i]) state_d[i] = MAN_ON;
                    MAN_ON:  if (lamp_evt[i]) state_d[i] = MAN_OFF;
                    AUTO_OFF: begin
                        if (presence[i] && dark) begin
                            state_d[i] = AUTO_ON;
                            timer_d[i] = HOLD_LOAD;
                        end
                    end
                    AUTO_ON: begin
                        if (!dark) begin
                            state_d[i] = AUTO_OFF;
                        end else if (presence[i]) begin
                            timer_d[i] = HOLD_LOAD;
                        end else if (timer_q[i] <= TW'(1)) begin
                            state_d[i] = AUTO_OFF;
                        end else begin
                            timer_d[i] = timer_q[i] - TW'(1);
                        end
                    end
                    default: state_d[i] = AUTO_OFF;
                endcase
            end
            lamp_next[i] = (state_d[i] == AUTO_ON) || (state_d[i] == MAN_ON);
            count_next   = count_next + CW'(lamp_next[i]);
        end
    end

    always_comb begin
        led_manual = '0;
        lamp_on    = '0;
        for (int i = 0; i < N_CH; i++) begin
            led_manual[i] = (state_q[i] == MAN_OFF) || (state_q[i] == MAN_ON);
            lamp_on[i]    = (state_q[i] == AUTO_ON) || (state_q[i] == MAN_ON);
        end
    end
endmodule

// File: tb/tb_smart_light_ctrl.sv
// Scoreboard bench for smart_light_ctrl: directed scenarios plus random stimulus,
// checked against a behavioural per-channel lamp model.
module tb_smart_light_ctrl;
    localparam int N_CH = 4;
    localparam int HOLD = 4;

    typedef struct packed {
        logic [3:0] man;
        logic [3:0] on;
        logic [2:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mode_btn = '0;
    logic [3:0] lamp_btn = '0;
    logic [3:0] presence = '0;
    logic       dark = 1'b0;
    logic       all_off = 1'b0;
    logic [3:0] led_manual;
    logic [3:0] lamp_on;
    logic [2:0] on_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t expq[$];

    // Model: whether each channel is manual, whether its lamp is lit, and how
    // many more presence-free edges an auto lamp survives.
    bit         m_man [4];
    bit         m_on  [4];
    int         m_left[4];
    logic [3:0] m_mprev = '0;
    logic [3:0] m_lprev = '0;

    smart_light_ctrl #(.N_CH(N_CH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .lamp_btn(lamp_btn),
        .presence(presence), .dark(dark), .all_off(all_off),
        .led_manual(led_manual), .lamp_on(lamp_on), .on_count(on_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input exp_t e);
        checks++;
        if ({led_manual, lamp_on, on_count} !== e) begin
            errors++;
            $display("[TB] FAIL %s: got man=%b on=%b cnt=%0d, expected man=%b on=%b cnt=%0d",
                     name, led_manual, lamp_on, on_count, e.man, e.on, e.cnt);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_man[i] = 0; m_on[i] = 0; m_left[i] = 0;
        end
        m_mprev = '0;
        m_lprev = '0;
    endtask

    task automatic modelStep(input logic [3:0] mb, lb, pr, input logic dk, ao, output exp_t e);
        logic mev, lev;
        for (int i = 0; i < 4; i++) begin
            mev = mb[i] & ~m_mprev[i];
            lev = lb[i] & ~m_lprev[i];
            if (ao) begin
                m_man[i] = 0; m_on[i] = 0; m_left[i] = 0;
            end else if (mev) begin
                m_man[i]  = !m_man[i];
                m_left[i] = (!m_man[i] && m_on[i]) ? HOLD : 0;
            end else if (m_man[i]) begin
                if (lev) m_on[i] = !m_on[i];
            end else if (!m_on[i]) begin
                if (pr[i] && dk) begin
                    m_on[i] = 1; m_left[i] = HOLD;
                end
            end else if (!dk) begin
                m_on[i] = 0; m_left[i] = 0;
            end else if (pr[i]) begin
                m_left[i] = HOLD;
            end else begin
                m_left[i]--;
                if (m_left[i] == 0) m_on[i] = 0;
            end
            e.man[i] = m_man[i];
            e.on[i]  = m_on[i];
        end
        e.cnt   = 3'($countones(e.on));
        m_mprev = mb;
        m_lprev = lb;
    endtask

    task automatic applyStimulus(input logic [3:0] mb, lb, pr, input logic dk, ao);
        exp_t e;
        @(negedge clk);
        mode_btn = mb; lamp_btn = lb; presence = pr; dark = dk; all_off = ao;
        modelStep(mb, lb, pr, dk, ao, e);
        expq.push_back(e);
    endtask

    task automatic idle(input int n, input logic [3:0] pr, input logic dk);
        for (int k = 0; k < n; k++) applyStimulus(4'h0, 4'h0, pr, dk, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while (expq.size() != 0 && k < 8) begin
            @(posedge clk); #2; k++;
        end
        if (expq.size() != 0) begin
            checks++; errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic doReset();
        drain();
        @(negedge clk);
        mode_btn = '0; lamp_btn = '0; presence = '0; dark = 1'b0; all_off = 1'b0;
        rst = 1'b1;
        #1 checkOutput("reset_async", '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    // Monitor: one expectation is consumed shortly after every active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst && expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput($sformatf("cycle %0d", cyc), e);
            end
        end
    end

    initial begin
        modelReset();
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_initial", '0);
        @(negedge clk) rst = 1'b0;

        // Auto timeout, then re-pulse at k+2 extending the hold.
        applyStimulus(4'h0, 4'h0, 4'b0001, 1'b1, 1'b0);
        idle(6, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'h0, 4'b0001, 1'b1, 1'b0);
        idle(1, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'h0, 4'b0001, 1'b1, 1'b0);
        idle(7, 4'h0, 1'b1);

        // Ambient gating on channel 1.
        idle(3, 4'b0010, 1'b0);
        idle(2, 4'b0010, 1'b1);
        idle(2, 4'b0010, 1'b0);
        idle(2, 4'h0, 1'b1);

        // Held mode button, two lamp pulses, then sensor activity in manual.
        for (int k = 0; k < 5; k++) applyStimulus(4'b0100, 4'h0, 4'h0, 1'b1, 1'b0);
        idle(1, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'b0100, 4'h0, 1'b1, 1'b0);
        idle(1, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'b0100, 4'h0, 1'b1, 1'b0);
        idle(2, 4'b0100, 1'b1);
        idle(2, 4'b0100, 1'b0);

        // Simultaneous mode+lamp edge on ch3 in AUTO_ON, all lamps on, then all_off.
        applyStimulus(4'h0, 4'h0, 4'b1000, 1'b1, 1'b0);
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0);
        applyStimulus(4'h0, 4'b0100, 4'b0011, 1'b1, 1'b0);
        idle(1, 4'b0011, 1'b1);
        applyStimulus(4'h0, 4'h0, 4'b0011, 1'b1, 1'b1);
        idle(2, 4'h0, 1'b1);

        // Mode restore on channel 0: MAN_ON back to auto, then timeout.
        applyStimulus(4'b0001, 4'h0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 4'b0001, 4'h0, 1'b1, 1'b0);
        idle(1, 4'h0, 1'b1);
        applyStimulus(4'b0001, 4'h0, 4'h0, 1'b1, 1'b0);
        idle(6, 4'h0, 1'b1);

        // All channels to MAN_ON, then reset mid-run.
        applyStimulus(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
        idle(1, 4'h0, 1'b1);
        doReset();
        idle(2, 4'h0, 1'b1);

        // Randomised traffic with one reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] mb, lb, pr;
            for (int b = 0; b < 4; b++) begin
                mb[b] = ($urandom_range(0, 4) == 0);
                lb[b] = ($urandom_range(0, 3) == 0);
                pr[b] = ($urandom_range(0, 9) < 4);
            end
            applyStimulus(mb, lb, pr, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
            if (n == 750) doReset();
        end

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/smart_light_ctrl.md
# smart_light_ctrl

Parametrised multi-channel lighting controller for the smart-lighting system. Each of `N_CH` channels runs its own four-state auto/manual lamp FSM with an occupancy hold-off timer, ambient-light gating, internal rising-edge detection on the user buttons, and a global all-off override. It sits between the debounced room inputs (buttons, presence sensors, light sensor) and the lamp drivers and mode LEDs, and reports how many lamps are lit.

## Interface
Parameters:
- `N_CH`, 4: number of independent lamp channels (≥1).
- `HOLD_CYCLES`, 1000: clock cycles a lamp in auto mode stays on after presence was last seen (≥1).

Ports:
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `mode_btn`  input  N_CH  per-channel auto/manual mode button, level; acts on its rising edge.
- `lamp_btn`  input  N_CH  per-channel manual on/off button, level; acts on its rising edge.
- `presence`  input  N_CH  per-channel occupancy sensor, level, 1 = occupied.
- `dark`  input  1  global ambient sensor, 1 = dark enough to need light.
- `all_off`  input  1  global override, level, 1 = force every channel off.
- `led_manual`  output  N_CH  1 = channel in manual mode.
- `lamp_on`  output  N_CH  1 = channel lamp driven on.
- `on_count`  output  $clog2(N_CH+1)  number of bits set in `lamp_on`.

## Operation
- Per channel, states: AUTO_OFF, AUTO_ON, MAN_OFF, MAN_ON. Outputs decode from state only: `led_manual` = 1 in MAN_*, `lamp_on` = 1 in *_ON.
- Edge detect: each button bit has a registered previous value, cleared by reset. Event = `btn & ~btn_prev`. A button held high produces exactly one event.
- Per-channel hold timer, width $clog2(HOLD_CYCLES+1). It only matters in AUTO_ON and is 0 in every other state.
- Transition priority per channel at each edge, first match wins:
  1. `all_off`=1: the channel goes to AUTO_OFF and its timer clears.
  2. Mode event: AUTO_OFF→MAN_OFF, AUTO_ON→MAN_ON, MAN_OFF→AUTO_OFF, MAN_ON→AUTO_ON with timer loaded to HOLD_CYCLES. The lamp state is preserved across the mode change.
  3. Lamp event, MAN_* only: MAN_OFF↔MAN_ON. Lamp events in AUTO_* are ignored.
  4. AUTO_OFF with `presence`=1 and `dark`=1: go to AUTO_ON and load the timer to HOLD_CYCLES.
  5. AUTO_ON with `dark`=0: go to AUTO_OFF.
  6. AUTO_ON with `presence`=1: stay in AUTO_ON and reload the timer to HOLD_CYCLES.
  7. AUTO_ON with `presence`=0: if the timer is 1, go to AUTO_OFF with timer 0; otherwise decrement the timer.
  8. Otherwise: hold.
- Manual states ignore `presence` and `dark`. Only `all_off` or a mode event leaves them.
- `all_off` held high keeps all channels in AUTO_OFF. Button edges occurring while it is high are consumed and lost; `btn_prev` still updates.
- Channels are fully independent except for the shared `dark` and `all_off` inputs.
- `on_count` is a registered population count of the next `lamp_on` value, so it is cycle-aligned with `lamp_on`.
- An illegal state encoding recovers to AUTO_OFF on the next edge.

## Timing
- Reset values: all channels AUTO_OFF, timers 0, `btn_prev` 0, `led_manual`=0, `lamp_on`=0, `on_count`=0.
- Reset asserted mid-operation returns everything to the reset values immediately. The first rising edge after deassertion evaluates inputs normally. A button already high at that edge counts as an event.
- Latency: an input condition sampled at edge k is visible on the outputs after edge k. This is one cycle of latency, with no combinational path from inputs to outputs.
- Auto hold: if `presence` is last sampled high at edge k, `lamp_on` falls after edge k+HOLD_CYCLES, provided `dark` stays 1. With HOLD_CYCLES=1, the lamp falls after the first edge where `presence`=0.
- `presence` returning while the timer is counting reloads the timer to HOLD_CYCLES with no gap in `lamp_on`.
- A mode event and a lamp event at the same edge: only the mode change is applied; the lamp event is dropped.

## Test plan
- Reset check, N_CH=4. Assert `rst` mid-run with channels in MAN_ON. Required: all outputs 0 immediately; after release, `on_count`=0.
- Auto timeout, HOLD_CYCLES=4, `dark`=1. Pulse `presence[0]` high for one edge k. Required: `lamp_on[0]`=1 after edge k and stays 1 through edge k+3, then 0 after edge k+4. Repeat with a presence re-pulse at k+2: the fall moves to after k+6.
- Ambient gating. With `dark`=0, `presence[1]`=1: `lamp_on[1]` stays 0. Raise `dark`: lamp on after the next edge. Drop `dark`: lamp off after the next edge, even though presence is still 1.
- Manual and edge detect. Hold `mode_btn[2]` high for 5 cycles: `led_manual[2]`=1 and stays 1, with exactly one toggle. Two separate `lamp_btn[2]` pulses: `lamp_on[2]` goes 1 then 0. `presence` and `dark` activity causes no change.
- Priority and override. A simultaneous mode and lamp edge on channel 3 in AUTO_ON gives MAN_ON. Then with channels 0–3 all on, `on_count`=4; assert `all_off`: after the next edge all outputs are 0, `on_count`=0 and `led_manual`=0.
- Mode restore. Take channel 0 from MAN_ON to auto with `presence`=0, `dark`=1, HOLD_CYCLES=4. Required: AUTO_ON, `lamp_on[0]` falls 4 edges after the mode edge.
